cpu_controller: RTL and testbench

- 8-phase instruction sequencer for the 8-bit accumulator CPU.
- Runs one fixed 8-cycle phase ring per instruction and drives every datapath strobe: address mux select, memory read/write, instruction-register load, PC increment/load, accumulator load and data-bus enable.
- Decodes the 3-bit opcode from the instruction register and the ALU zero flag; HLT parks the CPU until reset.
- Sits between the instruction register/ALU and the PC, memory and accumulator.

---
 rtl/cpu_controller_pkg.sv | 25 ++
 rtl/cpu_controller.sv | 67 ++++++
 tb/tb_cpu_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: phase encoding, opcode constants and ALU-opcode helper for the accumulator CPU.
`ifndef CPU_CONTROLLER_PKG_SV
`define CPU_CONTROLLER_PKG_SV
`define OPCODE_IS_ALUOP(op) ((op) == 3'b010 || (op) == 3'b011 || (op) == 3'b100 || (op) == 3'b101)
package cpu_controller_pkg;
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;
    localparam logic [2:0] OPCODE_HLT = 3'b000;
    localparam logic [2:0] OPCODE_SKZ = 3'b001;
    localparam logic [2:0] OPCODE_ADD = 3'b010;
    localparam logic [2:0] OPCODE_AND = 3'b011;
    localparam logic [2:0] OPCODE_XOR = 3'b100;
    localparam logic [2:0] OPCODE_LDA = 3'b101;
    localparam logic [2:0] OPCODE_STO = 3'b110;
    localparam logic [2:0] OPCODE_JMP = 3'b111;
endpackage
`endif

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer driving all datapath strobes; CTRL_SINGLE_STEP_EN adds i_step gating at INST_ADDR.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ena,
    input  logic [2:0]       i_opcode,
    input  logic             i_zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             i_step,
`endif
    output logic             o_sel,
    output logic             o_rd,
    output logic             o_wr,
    output logic             o_ld_ir,
    output logic             o_inc_pc,
    output logic             o_ld_pc,
    output logic             o_ld_ac,
    output logic             o_data_e,
    output logic             o_halted,
    output logic [2:0]       o_phase,
    output logic [CNT_W-1:0] o_instr_cnt
);
    phase_t r_phase;
    logic r_halted;
    logic [CNT_W-1:0] r_cnt;
    logic w_adv, w_halt, w_retire, w_run, w_alu, w_late;
`ifdef CTRL_SINGLE_STEP_EN
    assign w_adv = i_ena && !r_halted && (r_phase != PH_INST_ADDR || i_step);
`else
    assign w_adv = i_ena && !r_halted;
`endif
    assign w_halt   = w_adv && r_phase == PH_OP_ADDR && i_opcode == OPCODE_HLT;
    assign w_retire = w_adv && (r_phase == PH_STORE || w_halt);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_adv)
                r_phase <= w_halt ? PH_INST_ADDR : phase_t'(r_phase + 3'd1);
            if (w_halt)
                r_halted <= 1'b1;
            if (w_retire && !(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end
    end
    // Halt gates every strobe, including the otherwise-default PC address select.
    assign w_run  = !r_halted;
    assign w_alu  = `OPCODE_IS_ALUOP(i_opcode);
    assign w_late = r_phase == PH_ALU_OP || r_phase == PH_STORE;
    assign o_sel    = w_run && !r_phase[2];
    assign o_rd     = w_run && ((!r_phase[2] && r_phase != PH_INST_ADDR) || (r_phase[2] && r_phase != PH_OP_ADDR && w_alu));
    assign o_ld_ir  = w_run && (r_phase == PH_INST_LOAD || r_phase == PH_IDLE);
    assign o_inc_pc = w_run && (r_phase == PH_OP_ADDR || (r_phase == PH_ALU_OP && i_opcode == OPCODE_SKZ && i_zero));
    assign o_ld_pc  = w_run && w_late && i_opcode == OPCODE_JMP;
    assign o_ld_ac  = w_run && r_phase == PH_STORE && w_alu;
    assign o_wr     = w_run && r_phase == PH_STORE && i_opcode == OPCODE_STO;
    assign o_data_e = w_run && w_late && i_opcode == OPCODE_STO;
    assign o_halted    = r_halted;
    assign o_phase     = r_phase;
    assign o_instr_cnt = r_cnt;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed-vector bench for cpu_controller, plus a CNT_W=2 instance for counter saturation.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic rst, ena, zero;
    logic [2:0] opcode;
    logic sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halted;
    logic [2:0] phase;
    logic [15:0] instr_cnt;
    logic s_sel, s_rd, s_wr, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_data_e, s_halted;
    logic [2:0] s_phase;
    logic [1:0] s_cnt;
    logic [7:0] strb;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    cpu_controller u_dut (
        .clk(clk), .rst(rst), .i_ena(ena), .i_opcode(opcode), .i_zero(zero),
        .o_sel(sel), .o_rd(rd), .o_wr(wr), .o_ld_ir(ld_ir), .o_inc_pc(inc_pc),
        .o_ld_pc(ld_pc), .o_ld_ac(ld_ac), .o_data_e(data_e), .o_halted(halted),
        .o_phase(phase), .o_instr_cnt(instr_cnt)
    );
    cpu_controller #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .i_ena(ena), .i_opcode(opcode), .i_zero(zero),
        .o_sel(s_sel), .o_rd(s_rd), .o_wr(s_wr), .o_ld_ir(s_ld_ir), .o_inc_pc(s_inc_pc),
        .o_ld_pc(s_ld_pc), .o_ld_ac(s_ld_ac), .o_data_e(s_data_e), .o_halted(s_halted),
        .o_phase(s_phase), .o_instr_cnt(s_cnt)
    );
    // Strobe byte order: {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e}
    assign strb = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_instr(input string name, input logic [2:0] op, input logic z, input logic [63:0] exp);
        opcode = op;
        zero = z;
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s phase%0d", name, p), 32'(phase), 32'(p));
            check($sformatf("%s strobes%0d", name, p), 32'(strb), 32'(exp[63-8*p -: 8]));
            tick();
        end
    endtask
    initial begin
        rst = 1'b1;
        ena = 1'b0;
        zero = 1'b0;
        opcode = 3'b010;
        tick();
        tick();
        rst = 1'b0;
        ena = 1'b1;
        repeat (5) tick();
        check("pre-reset phase", 32'(phase), 32'd5);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset phase", 32'(phase), 32'd0);
        check("reset strobes", 32'(strb), 32'h80);
        check("reset cnt", 32'(instr_cnt), 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        run_instr("ADD", 3'b010, 1'b0, 64'h80C0D0D008404042);
        check("cnt after ADD", 32'(instr_cnt), 32'd1);
        run_instr("SKZ1", 3'b001, 1'b1, 64'h80C0D0D008000800);
        run_instr("SKZ0", 3'b001, 1'b0, 64'h80C0D0D008000000);
        run_instr("STO", 3'b110, 1'b0, 64'h80C0D0D008000121);
        run_instr("JMP", 3'b111, 1'b0, 64'h80C0D0D008000404);
        check("cnt after 5", 32'(instr_cnt), 32'd5);
        check("sat cnt", 32'(s_cnt), 32'd3);
        opcode = 3'b010;
        repeat (6) tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold phase", 32'(phase), 32'd6);
            check("hold strobes", 32'(strb), 32'h40);
        end
        ena = 1'b1;
        tick();
        tick();
        check("post-hold phase", 32'(phase), 32'd0);
        check("post-hold cnt", 32'(instr_cnt), 32'd6);
        check("sat cnt held", 32'(s_cnt), 32'd3);
        opcode = 3'b000;
        repeat (4) tick();
        check("HLT phase4", 32'(phase), 32'd4);
        check("HLT strobes4", 32'(strb), 32'h08);
        check("HLT not yet", 32'(halted), 32'd0);
        tick();
        check("HLT halted", 32'(halted), 32'd1);
        check("HLT phase", 32'(phase), 32'd0);
        check("HLT strobes", 32'(strb), 32'h00);
        check("HLT cnt", 32'(instr_cnt), 32'd7);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halted phase", 32'(phase), 32'd0);
            check("halted strobes", 32'(strb), 32'h00);
            check("halted flag", 32'(halted), 32'd1);
        end
        check("halted cnt", 32'(instr_cnt), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("unhalt flag", 32'(halted), 32'd0);
        check("unhalt strobes", 32'(strb), 32'h80);
        check("unhalt cnt", 32'(instr_cnt), 32'd0);
        opcode = 3'b010;
        tick();
        check("unhalt runs", 32'(phase), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
